// File: rtl/sha512_modq_arb_pkg.sv
// Shared types for the SHA-512/mod-q lane arbiter.
// Block meta, skid entry and FSM state.
package sha512_modq_arb_pkg;

    localparam int SHA_ARB_N_MAX = 16;
    localparam int SHA_ARB_ID_W  = $clog2(SHA_ARB_N_MAX);

    typedef struct packed {
        logic       f;
        logic [6:0] tag;
    } sv_meta3_t;

    localparam int META_W = $bits(sv_meta3_t);

    typedef struct packed {
        logic                    e;
        sv_meta3_t               m;
        logic [SHA_ARB_ID_W-1:0] id;
    } sv_arb_ent_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_st_t;

endpackage

// File: rtl/sha512_modq_arb_if.sv
// Lane-side and datapath-side bundle of the arbiter.
// slave is the arbiter view, master the surrounding logic.
interface sha512_modq_arb_if #(
    parameter int N   = 4,
    parameter int N_L = $clog2(N)
);
    import sha512_modq_arb_pkg::*;

    logic [N-1:0]        x_v;
    logic [N-1:0]        x_e;
    logic [N*META_W-1:0] x_m;
    logic [N-1:0]        x_r;
    logic [N-1:0]        en;
    logic                hold;
    logic                o_v;
    logic                o_e;
    sv_meta3_t           o_m;
    logic [N_L-1:0]      o_id;
    logic                o_r;
    logic                busy;
    logic                err;
    logic [N_L-1:0]      err_id;

    modport slave (
        input  x_v, x_e, x_m, en, hold, o_r,
        output x_r, o_v, o_e, o_m, o_id, busy, err, err_id
    );

    modport master (
        output x_v, x_e, x_m, en, hold, o_r,
        input  x_r, o_v, o_e, o_m, o_id, busy, err, err_id
    );

endinterface

// File: rtl/sha512_modq_arb_skid2.sv
// Two-entry registered skid buffer.
// Head entry is presented; push at count 2 is not expected.
module sha512_modq_arb_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         rdy,
    output logic         vld,
    output logic [W-1:0] dout,
    output logic [1:0]   cnt
);

    logic [W-1:0] h_q;
    logic [W-1:0] t_q;
    logic [1:0]   c_q;
    logic         pop;

    assign vld  = (c_q != 2'd0);
    assign pop  = vld & rdy;
    assign dout = h_q;
    assign cnt  = c_q;

    // head/tail storage and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            t_q <= '0;
            c_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (c_q == 2'd0) h_q <= din;
                    else             t_q <= din;
                    c_q <= c_q + 2'd1;
                end
                2'b01: begin
                    h_q <= t_q;
                    c_q <= c_q - 2'd1;
                end
                2'b11: begin
                    if (c_q == 2'd1) begin
                        h_q <= din;
                    end else begin
                        h_q <= t_q;
                        t_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sha512_modq_arb.sv
// Message-atomic round-robin arbiter in front of the
// SHA-512/mod-q datapath, with framing check and skid.
module sha512_modq_arb
    import sha512_modq_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int N_L = $clog2(N)
) (
    input logic clk,
    input logic rst_n,
    sha512_modq_arb_if.slave bus
);

    localparam int EW = $bits(sv_arb_ent_t);

    arb_st_t        st_q;
    arb_st_t        st_d;
    logic [N_L-1:0] g_q;
    logic [N_L-1:0] ptr_q;
    logic [N_L-1:0] pick;
    logic [N_L-1:0] eid_q;
    logic           first_q;
    logic           err_q;
    logic           found;
    logic           grant;
    logic           acc;
    logic           last;
    logic           bad;
    logic           full;
    logic [1:0]     cnt;
    logic [N-1:0]   xr;
    sv_meta3_t      m_g;
    sv_arb_ent_t    ent_d;
    sv_arb_ent_t    ent_q;
    logic [EW-1:0]  dout;

    assign full  = (cnt == 2'd2);
    assign m_g   = bus.x_m[int'(g_q)*META_W +: META_W];
    assign acc   = (st_q == LOCK) & bus.x_v[g_q] & ~full;
    assign last  = acc & bus.x_e[g_q];
    assign bad   = acc & (m_g.f != first_q);
    assign grant = (st_q == IDLE) & found & ~bus.hold & ~full;

    // first enabled requester at or after ptr, cyclically
    always_comb begin
        int k;
        found = 1'b0;
        pick  = '0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_q) + i;
            if (k >= N) k = k - N;
            if (!found && bus.x_v[k] && bus.en[k]) begin
                found = 1'b1;
                pick  = N_L'(k);
            end
        end
    end

    // only the granted lane may see accept
    always_comb begin
        xr = '0;
        if (st_q == LOCK && !full) xr[g_q] = 1'b1;
    end

    // next state: grant at boundary, release on last block
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE: if (grant) st_d = LOCK;
            LOCK: if (last)  st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= IDLE;
        else        st_q <= st_d;
    end

    // grant, pointer and sticky framing error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q     <= '0;
            ptr_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            eid_q   <= '0;
        end else begin
            if (grant) begin
                g_q     <= pick;
                first_q <= 1'b1;
            end
            if (acc) first_q <= 1'b0;
            if (last) begin
                ptr_q <= (g_q == N_L'(N-1)) ? '0 : g_q + 1'b1;
            end
            if (bad && !err_q) begin
                err_q <= 1'b1;
                eid_q <= g_q;
            end
        end
    end

    // entry pushed into the skid
    always_comb begin
        ent_d    = '0;
        ent_d.e  = bus.x_e[g_q];
        ent_d.m  = m_g;
        ent_d.id = SHA_ARB_ID_W'(g_q);
    end

    sha512_modq_arb_skid2 #(.W(EW)) u_skid (
        .clk  (clk),
        .rst_n(rst_n),
        .push (acc),
        .din  (ent_d),
        .rdy  (bus.o_r),
        .vld  (bus.o_v),
        .dout (dout),
        .cnt  (cnt)
    );

    assign ent_q      = sv_arb_ent_t'(dout);
    assign bus.o_e    = ent_q.e;
    assign bus.o_m    = ent_q.m;
    assign bus.o_id   = N_L'(ent_q.id);
    assign bus.x_r    = xr;
    assign bus.busy   = (st_q == LOCK) | (cnt != 2'd0);
    assign bus.err    = err_q;
    assign bus.err_id = eid_q;

endmodule

// File: tb/tb_sha512_modq_arb.sv
// Scoreboard bench for the lane arbiter.
// Lane queues feed blocks; expected outputs are queued in order.
module tb_sha512_modq_arb;
    import sha512_modq_arb_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sha512_modq_arb_if #(.N(N)) bus ();

    sha512_modq_arb #(.N(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    sv_arb_ent_t lq[N][$];
    sv_arb_ent_t sb[$];
    int          lat_q[$];
    int          errs = 0;
    int          checks = 0;
    int          cyc = 0;
    int          seq = 0;
    int          acc_cnt[N];
    logic [N-1:0] acc_p;
    bit          chk_lat = 1'b0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic void send(int lane, int n, bit bad_f,
                                 bit bad_l, bit to_sb);
        sv_arb_ent_t x;
        for (int b = 0; b < n; b++) begin
            x       = '0;
            x.e     = (b == n - 1);
            x.m.f   = (b == 0) ? ~bad_f : bad_l;
            x.m.tag = 7'(seq);
            x.id    = SHA_ARB_ID_W'(lane);
            seq++;
            lq[lane].push_back(x);
            if (to_sb) sb.push_back(x);
        end
    endfunction

    task automatic drive();
        logic [N-1:0]        v;
        logic [N-1:0]        e;
        logic [N*META_W-1:0] m;
        v = '0;
        e = '0;
        m = '0;
        for (int k = 0; k < N; k++) begin
            if (lq[k].size() != 0) begin
                v[k] = 1'b1;
                e[k] = lq[k][0].e;
                m[k*META_W +: META_W] = lq[k][0].m;
            end
        end
        bus.x_v = v;
        bus.x_e = e;
        bus.x_m = m;
    endtask

    task automatic tick();
        sv_arb_ent_t x;
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (bus.x_v[k] && bus.x_r[k]) begin
                    acc_p[k] = 1'b1;
                    acc_cnt[k]++;
                    if (chk_lat) lat_q.push_back(cyc);
                end
            end
            if (bus.o_v && bus.o_r) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'(bus.o_id), 32'hffff_ffff);
                end else begin
                    x = sb.pop_front();
                    chk("o_id", 32'(bus.o_id), 32'(x.id));
                    chk("o_e", 32'(bus.o_e), 32'(x.e));
                    chk("o_m", 32'(bus.o_m), 32'(x.m));
                    if (chk_lat && lat_q.size() != 0)
                        chk("latency", 32'(cyc), 32'(lat_q.pop_front() + 1));
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc_p[k]) begin
                if (lq[k].size() != 0) void'(lq[k].pop_front());
                acc_p[k] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            lq[k].delete();
            acc_cnt[k] = 0;
        end
        sb.delete();
        lat_q.delete();
        acc_p = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain(int left, int maxc);
        int n;
        n = 0;
        while (!(sb.size() == left && !bus.busy)) begin
            tick();
            n++;
            if (n > maxc) begin
                chk("drain_timeout", 32'(sb.size()), 32'(left));
                break;
            end
        end
    endtask

    task automatic wait_acc(int lane, int cnt_req, int maxc);
        int n;
        n = 0;
        while (acc_cnt[lane] < cnt_req) begin
            tick();
            n++;
            if (n > maxc) begin
                chk("acc_timeout", 32'(acc_cnt[lane]), 32'(cnt_req));
                break;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.x_v  = '0;
        bus.x_e  = '0;
        bus.x_m  = '0;
        bus.en   = '1;
        bus.hold = 1'b0;
        bus.o_r  = 1'b1;
        acc_p    = '0;

        do_reset();
        chk("rst_o_v", 32'(bus.o_v), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_x_r", 32'(bus.x_r), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_id", 32'(bus.err_id), 32'd0);

        // single lane, 3 blocks, latency one cycle
        chk_lat = 1'b1;
        send(0, 3, 1'b0, 1'b0, 1'b1);
        drain(0, 40);
        chk_lat = 1'b0;
        lat_q.delete();
        chk("single_busy", 32'(bus.busy), 32'd0);
        chk("single_err", 32'(bus.err), 32'd0);
        chk("single_acc", 32'(acc_cnt[0]), 32'd3);

        // ptr now 1: lane 1 wins over lane 0
        send(1, 1, 1'b0, 1'b0, 1'b1);
        send(0, 1, 1'b0, 1'b0, 1'b1);
        drain(0, 40);

        // two 2-block messages never interleave
        do_reset();
        send(1, 2, 1'b0, 1'b0, 1'b1);
        send(2, 2, 1'b0, 1'b0, 1'b1);
        drain(0, 40);

        // fairness over 100 single-block messages
        do_reset();
        for (int r = 0; r < 25; r++)
            for (int k = 0; k < N; k++)
                send(k, 1, 1'b0, 1'b0, 1'b1);
        drain(0, 400);
        for (int k = 0; k < N; k++)
            chk($sformatf("fair_lane%0d", k), 32'(acc_cnt[k]), 32'd25);

        // backpressure mid-message
        do_reset();
        send(0, 6, 1'b0, 1'b0, 1'b1);
        wait_acc(0, 2, 20);
        bus.o_r = 1'b0;
        repeat (5) begin
            tick();
            if (sb.size() != 0) begin
                chk("stall_o_m", 32'(bus.o_m), 32'(sb[0].m));
                chk("stall_o_id", 32'(bus.o_id), 32'(sb[0].id));
            end
            chk("stall_o_v", 32'(bus.o_v), 32'd1);
        end
        chk("stall_x_r", 32'(bus.x_r), 32'd0);
        chk("stall_busy", 32'(bus.busy), 32'd1);
        bus.o_r = 1'b1;
        drain(0, 40);
        chk("bp_acc", 32'(acc_cnt[0]), 32'd6);

        // framing errors: first sticks
        do_reset();
        send(3, 2, 1'b1, 1'b0, 1'b1);
        drain(0, 40);
        chk("frm_err", 32'(bus.err), 32'd1);
        chk("frm_err_id", 32'(bus.err_id), 32'd3);
        send(1, 2, 1'b0, 1'b1, 1'b1);
        drain(0, 40);
        chk("frm2_err", 32'(bus.err), 32'd1);
        chk("frm2_err_id", 32'(bus.err_id), 32'd3);

        // hold mid-message: message completes, no new grant
        do_reset();
        send(0, 4, 1'b0, 1'b0, 1'b1);
        wait_acc(0, 1, 20);
        bus.hold = 1'b1;
        send(1, 1, 1'b0, 1'b0, 1'b1);
        drain(1, 40);
        repeat (6) tick();
        chk("hold_acc0", 32'(acc_cnt[0]), 32'd4);
        chk("hold_acc1", 32'(acc_cnt[1]), 32'd0);
        chk("hold_busy", 32'(bus.busy), 32'd0);
        bus.hold = 1'b0;
        drain(0, 40);
        chk("hold_rel_acc1", 32'(acc_cnt[1]), 32'd1);

        // disabled lane 2 is skipped
        do_reset();
        bus.en = 4'b1011;
        send(1, 1, 1'b0, 1'b0, 1'b1);
        send(2, 1, 1'b0, 1'b0, 1'b0);
        send(3, 1, 1'b0, 1'b0, 1'b1);
        drain(0, 40);
        repeat (10) tick();
        chk("en_acc2", 32'(acc_cnt[2]), 32'd0);
        chk("en_pending2", 32'(lq[2].size()), 32'd1);
        do_reset();
        bus.en = '1;

        // asynchronous reset mid-message
        bus.o_r = 1'b0;
        send(0, 4, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_o_v", 32'(bus.o_v), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_x_r", 32'(bus.x_r), 32'd0);
        bus.o_r = 1'b1;
        do_reset();
        send(0, 2, 1'b0, 1'b0, 1'b1);
        drain(0, 40);
        chk("post_rst_err", 32'(bus.err), 32'd0);
        chk("post_rst_acc", 32'(acc_cnt[0]), 32'd2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sha512_modq_arb.md
# sha512_modq_arb

Message-atomic round-robin arbiter that shares one `sha512_modq_meta` instance between `N` requester lanes. It grants a lane at a message boundary, holds the grant until that lane's last block is accepted, and forwards blocks through a registered 2-entry skid stage. It sits between the per-lane block formatters and the SHA-512/mod-q datapath input.

## Interface
- `N`, 4: number of requester lanes (2..16).
- `N_L`, `$clog2(N)`: lane index width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `x_v`  in  N  per-lane block valid.
- `x_e`  in  N  per-lane last block of message.
- `x_m`  in  N*`$bits(sv_meta3_t)`  per-lane meta; lane k occupies slice k; field `.f` marks the first block.
- `x_r`  out  N  per-lane accept; a block transfers when `x_v[k] & x_r[k]`.
- `en`  in  N  lane enable mask; affects new grants only.
- `hold`  in  1  no new grants while high; a granted message completes.
- `o_v`  out  1  block valid to datapath.
- `o_e`  out  1  last block.
- `o_m`  out  `$bits(sv_meta3_t)`  block meta.
- `o_id`  out  `N_L`  source lane of the block.
- `o_r`  in  1  datapath ready; the datapath `i_r`.
- `busy`  out  1  grant held or skid non-empty.
- `err`  out  1  sticky framing error.
- `err_id`  out  `N_L`  lane of the first framing error.

## Operation
- FSM states:
  - IDLE: no grant.
  - LOCK: grant to lane `g`.
- IDLE → LOCK(g) when at least one lane k has `x_v[k] & en[k]`, `hold` is low, and the skid has space. `g` is the first such lane at or after `ptr`, searching cyclically.
- In LOCK(g) only `x_r[g]` may be high. `x_r[g]` = skid not full.
- LOCK → IDLE on the cycle the block with `x_e[g]=1` is accepted. At that transfer `ptr` becomes `(g+1) mod N`, wrapping from N-1 to 0.
- A single-block message (`f=1`, `e=1`) grants and releases in one accept. The next grant can be issued on the following cycle.
- The grant decision is registered. The first block of a newly granted lane is accepted no earlier than the cycle after grant.
- `en` and `hold` are sampled only in IDLE. Dropping `en[g]` or raising `hold` during LOCK does not abort the message.
- Framing check, evaluated on every accepted block of lane g:
  - The first accepted block after a grant must have `.f=1`.
  - Later blocks of that message must have `.f=0`.
  - On violation, `err` sets and `err_id` latches g, both only if `err` is still clear. The block is still forwarded.
  - `err` clears only on reset.
- Skid stage: 2 entries of {e, m, id}.
  - `o_v` = skid not empty; it presents the head entry.
  - The head entry pops when `o_v & o_r`.
  - A simultaneous push and pop at count 2 is impossible, because `x_r` is low when the skid is full.
  - A simultaneous push and pop at count 1 keeps count at 1.
- `o_r` is honoured on every block. The arbiter does not rely on the datapath ignoring backpressure for non-first blocks.
- `busy` = (state==LOCK) | skid count != 0.

## Timing
- Reset (`rst_n` low, asynchronous) forces:
  - state IDLE, `ptr`=0, skid empty;
  - `o_v`=0, `x_r`=0, `busy`=0, `err`=0, `err_id`=0.
  - `o_e`, `o_m`, `o_id` are don't-care while `o_v`=0.
- Reset mid-message discards the message and any skid contents. After release, lanes must restart with `f=1`.
- Latency: a block accepted at cycle t appears on `o_v` at t+1 if the skid was empty.
- Throughput: one block per cycle with `o_r` held high. At a message boundary there is a one-cycle bubble for the grant.
- `o_v`, `o_e`, `o_m` and `o_id` stay stable while `o_v & ~o_r`.
- Outputs are registered. `x_r` is combinational from state, `g` and skid count only. It has no path from `x_v` or `o_r`.

## Structure
- Keep `sv_meta3_t` in the shared package. Add `sv_arb_ent_t` = {e, m, id} there.
- Add `SHA_ARB_N_MAX`=16 to the shared package.
- Natural sub-module: `skid2`, a generic 2-entry registered skid buffer parameterised by width.
- The round-robin priority search stays inline.

## Test plan
- Single lane: lane 0 sends 3 blocks (f=1,0,0; e=0,0,1) with `o_r`=1 → `o_v` at cycles t+1..t+3, `o_id`=0, `ptr`=1 after the last block, FSM returns to IDLE.
- Interleave attempt with N=4: lanes 1 and 2 both hold 2-block messages → all of lane 1's blocks come out before lane 2's. No interleaving appears on `o_id`.
- Fairness: all 4 lanes continuously valid with 1-block messages → grant order 0,1,2,3,0,…; each lane gets exactly 25% of accepts over 400 cycles.
- Backpressure: `o_r`=0 for 5 cycles mid-message → skid fills to 2, `x_r[g]` drops, `o_m` stays stable; on resume, the block order is preserved with no loss or duplication.
- Framing error: lane 3 first block with f=0 → `err`=1, `err_id`=3, block still forwarded. A later error on lane 1 leaves `err_id`=3.
- `hold`/`en`/reset: `hold` raised mid-message → message completes and no new grant is issued. `en[2]`=0 → lane 2 is never granted. `rst_n` low mid-message → `o_v`=0 and `busy`=0 asynchronously.
